// File: rtl/tcdm_bank_pkg.sv
// Shared types and helpers for the TCDM bank responder.
// Response stage bundle plus the byte-masked write merge.
package tcdm_bank_pkg;

  localparam int unsigned BankDataWidth = 32;
  localparam int unsigned BankBeWidth = BankDataWidth / 8;

  typedef logic [BankDataWidth-1:0] bank_data_t;
  typedef logic [BankBeWidth-1:0] bank_be_t;

  typedef struct packed {
    logic valid;
    logic is_load;
    bank_data_t data;
  } resp_stage_t;

  function automatic bank_data_t be_merge(
    input bank_data_t old_w,
    input bank_data_t new_w,
    input bank_be_t be
  );
    bank_data_t res;
    for (int b = 0; b < int'(BankBeWidth); b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8]
                            : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-latency response shift register with async clear.
// o_next is the value about to enter the last stage.
module tcdm_resp_pipe
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  resp_stage_t i_stage,
  output resp_stage_t o_next,
  output logic        o_last_valid,
  output logic        o_last_load
);

  resp_stage_t r_stage [Depth];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_stage;
      for (int i = 1; i < int'(Depth); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  generate
    if (Depth == 1) begin : g_d1
      assign o_next = i_stage;
    end else begin : g_dn
      assign o_next = r_stage[Depth-2];
    end
  endgenerate

  assign o_last_valid = r_stage[Depth-1].valid;
  assign o_last_load  = r_stage[Depth-1].is_load;

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single-ported TCDM bank terminating one crossbar slave port.
// Grant is combinational; responses return RespLat cycles later.
module tcdm_bank_responder
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned NumWords    = 64,
  parameter int unsigned DataWidth   = BankDataWidth,
  parameter int unsigned RespLat     = 1,
  parameter bit          WriteRespOn = 1'b1,
  localparam int unsigned AddrWidth  = $clog2(NumWords),
  localparam int unsigned BeWidth    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] add_i,
  input  logic                 wen_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 vld_o,
  input  logic                 stall_i
);

  generate
    if (RespLat < 1) begin : g_bad_lat
      $error("RespLat must be at least 1");
    end
    if ((NumWords < 2) ||
        ((NumWords & (NumWords - 1)) != 0)) begin : g_bad_depth
      $error("NumWords must be a power of two >= 2");
    end
    if ((DataWidth % 8) != 0) begin : g_bad_width
      $error("DataWidth must be a multiple of 8");
    end
    // The stage bundle width is fixed by the shared package.
    if (DataWidth != BankDataWidth) begin : g_bad_pkg
      $error("DataWidth must match BankDataWidth");
    end
  endgenerate

  logic [DataWidth-1:0] r_mem [NumWords];
  logic [DataWidth-1:0] r_rdata;
  logic                 w_acc;
  resp_stage_t          w_in;
  resp_stage_t          w_next;
  logic                 w_last_valid;
  logic                 w_last_load;

  assign gnt_o = req_i & ~stall_i;
  assign w_acc = req_i & gnt_o;

  always_comb begin
    w_in = '0;
    w_in.valid = w_acc;
    w_in.is_load = w_acc & ~wen_i;
    if (w_acc & ~wen_i) begin
      w_in.data = r_mem[add_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumWords); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_acc & wen_i) begin
      r_mem[add_i] <= be_merge(r_mem[add_i],
                               wdata_i, be_i);
    end
  end

  tcdm_resp_pipe #(
    .Depth (RespLat)
  ) u_pipe (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_stage      (w_in),
    .o_next       (w_next),
    .o_last_valid (w_last_valid),
    .o_last_load  (w_last_load)
  );

  // Loaded as the response enters the last stage so data and vld align.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (w_next.valid & w_next.is_load) begin
      r_rdata <= w_next.data;
    end
  end

  assign rdata_o = r_rdata;
  assign vld_o = w_last_valid &
                 (w_last_load | WriteRespOn);

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder across three configurations.
// A: RespLat=1, B: RespLat=3 without write responses, C: RespLat=2.
module tb_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_c = 1'b1;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic        stall = 1'b0;
  logic [5:0]  add = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;

  logic        gnt_a, gnt_b, gnt_c;
  logic        vld_a, vld_b, vld_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  tcdm_bank_responder #(
    .NumWords (64), .DataWidth (32),
    .RespLat (1), .WriteRespOn (1'b1)
  ) u_a (
    .clk_i (clk), .rst_i (rst), .req_i (req),
    .gnt_o (gnt_a), .add_i (add), .wen_i (wen),
    .be_i (be), .wdata_i (wdata),
    .rdata_o (rdata_a), .vld_o (vld_a),
    .stall_i (stall)
  );

  tcdm_bank_responder #(
    .NumWords (64), .DataWidth (32),
    .RespLat (3), .WriteRespOn (1'b0)
  ) u_b (
    .clk_i (clk), .rst_i (rst), .req_i (req),
    .gnt_o (gnt_b), .add_i (add), .wen_i (wen),
    .be_i (be), .wdata_i (wdata),
    .rdata_o (rdata_b), .vld_o (vld_b),
    .stall_i (stall)
  );

  tcdm_bank_responder #(
    .NumWords (64), .DataWidth (32),
    .RespLat (2), .WriteRespOn (1'b1)
  ) u_c (
    .clk_i (clk), .rst_i (rst_c), .req_i (req),
    .gnt_o (gnt_c), .add_i (add), .wen_i (wen),
    .be_i (be), .wdata_i (wdata),
    .rdata_o (rdata_c), .vld_o (vld_c),
    .stall_i (stall)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic w,
                       input logic [5:0] a,
                       input logic [3:0] b,
                       input logic [31:0] d);
    req = r;
    wen = w;
    add = a;
    be = b;
    wdata = d;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 6'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_vld_a", 32'(vld_a), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'h0);
    chk("rst_vld_b", 32'(vld_b), 32'd0);
    chk("rst_rdata_c", rdata_c, 32'h0);
    chk("rst_gnt_req", 32'(gnt_a), 32'd1);
    stall = 1'b1;
    #1;
    chk("rst_gnt_stall", 32'(gnt_a), 32'd0);
    next_cyc();
    rst = 1'b0;
    rst_c = 1'b0;
    stall = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
    next_cyc();

    drive(1'b1, 1'b1, 6'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("c0_gnt", 32'(gnt_a), 32'd1);
    next_cyc();

    drive(1'b1, 1'b0, 6'd5, 4'h0, 32'h0);
    @(negedge clk);
    chk("c1_wr_vld_a", 32'(vld_a), 32'd1);
    next_cyc();

    drive(1'b1, 1'b1, 6'd3, 4'hF, 32'h11223344);
    @(negedge clk);
    chk("c2_vld_a", 32'(vld_a), 32'd1);
    chk("c2_rdata_a", rdata_a, 32'hDEADBEEF);
    next_cyc();

    drive(1'b1, 1'b1, 6'd3, 4'h5, 32'hAABBCCDD);
    @(negedge clk);
    chk("c3_wr_vld_a", 32'(vld_a), 32'd1);
    chk("c3_hold_a", rdata_a, 32'hDEADBEEF);
    chk("c3_nowr_vld_b", 32'(vld_b), 32'd0);
    next_cyc();

    drive(1'b1, 1'b0, 6'd3, 4'h0, 32'h0);
    @(negedge clk);
    chk("c4_vld_b", 32'(vld_b), 32'd1);
    chk("c4_rdata_b", rdata_b, 32'hDEADBEEF);
    next_cyc();

    drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("c5_vld_a", 32'(vld_a), 32'd1);
    chk("c5_be_rdata_a", rdata_a, 32'h11BB33DD);
    chk("c5_nowr_vld_b", 32'(vld_b), 32'd0);
    chk("c5_hold_b", rdata_b, 32'hDEADBEEF);
    next_cyc();

    @(negedge clk);
    chk("c6_idle_vld_a", 32'(vld_a), 32'd0);
    chk("c6_nowr_vld_b", 32'(vld_b), 32'd0);
    chk("c6_hold_b", rdata_b, 32'hDEADBEEF);
    next_cyc();

    @(negedge clk);
    chk("c7_vld_b", 32'(vld_b), 32'd1);
    chk("c7_be_rdata_b", rdata_b, 32'h11BB33DD);
    next_cyc();

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 6'(i), 4'hF,
            32'hC0DE0000 | 32'(i));
      next_cyc();
    end
    for (int t = 0; t < 12; t++) begin
      if (t < 8) drive(1'b1, 1'b0, 6'(t), 4'h0, 32'h0);
      else drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("sweep_vld_t%0d", t), 32'(vld_b),
          32'((t >= 3) && (t < 11)));
      if ((t >= 3) && (t < 11)) begin
        chk($sformatf("sweep_data_t%0d", t), rdata_b,
            32'hC0DE0000 | 32'(t - 3));
      end
      next_cyc();
    end

    drive(1'b1, 1'b0, 6'd2, 4'h0, 32'h0);
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 6'd2, 4'hF, 32'hFFFFFFFF);
      stall = 1'b1;
      @(negedge clk);
      chk($sformatf("stall_gnt_%0d", k), 32'(gnt_a), 32'd0);
      if (k == 2) begin
        chk("stall_inflight_vld_b", 32'(vld_b), 32'd1);
        chk("stall_inflight_data_b", rdata_b, 32'hC0DE0002);
      end
      next_cyc();
    end
    stall = 1'b0;
    drive(1'b1, 1'b0, 6'd2, 4'h0, 32'h0);
    @(negedge clk);
    chk("unstall_gnt", 32'(gnt_a), 32'd1);
    next_cyc();
    drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("unstall_vld_a", 32'(vld_a), 32'd1);
    chk("stall_nowrite_a", rdata_a, 32'hC0DE0002);
    next_cyc();

    drive(1'b1, 1'b1, 6'd9, 4'hF, 32'h00000055);
    next_cyc();
    drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
    next_cyc();
    next_cyc();
    drive(1'b1, 1'b0, 6'd9, 4'h0, 32'h0);
    next_cyc();
    drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
    rst_c = 1'b1;
    @(negedge clk);
    chk("rstm_vld_c", 32'(vld_c), 32'd0);
    chk("rstm_rdata_c", rdata_c, 32'h0);
    chk("rstm_ref_a", rdata_a, 32'h00000055);
    next_cyc();
    rst_c = 1'b0;
    @(negedge clk);
    chk("rstm_drop_vld_c", 32'(vld_c), 32'd0);
    chk("rstm_drop_rdata_c", rdata_c, 32'h0);
    next_cyc();
    drive(1'b1, 1'b0, 6'd9, 4'h0, 32'h0);
    @(negedge clk);
    chk("rstm_idle_vld_c", 32'(vld_c), 32'd0);
    next_cyc();
    drive(1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rstm_pre_vld_c", 32'(vld_c), 32'd0);
    chk("rstm_keep_a", rdata_a, 32'h00000055);
    next_cyc();
    @(negedge clk);
    chk("rstm_reload_vld_c", 32'(vld_c), 32'd1);
    chk("rstm_reload_data_c", rdata_c, 32'h0);
    next_cyc();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
